// File: rtl/nibble_sweep_capture.sv
// Stimulus/readback end for a 4-in/1-out reduction block: sweeps every input code,
// captures the resulting truth table and compares it with an expected table latched at start.
module nibble_sweep_capture #(
  parameter int IN_W          = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [(2**IN_W)-1:0]   expected_tt,
  output logic [IN_W-1:0]        drv_in1,
  input  logic                   dut_out1,
  output logic                   busy,
  output logic                   done,
  output logic [(2**IN_W)-1:0]   tt,
  output logic                   pass,
  output logic [IN_W:0]          fail_cnt,
  output logic [IN_W-1:0]        fail_idx
);

  // state    | meaning
  // S_IDLE   | waiting for start, drv_in1 parked at 0
  // S_DRIVE  | holding code idx on drv_in1 for SETTLE_CYCLES cycles
  // S_SAMPLE | capturing dut_out1 for code idx, comparing with expected
  // S_DONE   | one-cycle completion pulse, pass verdict latched
  localparam int TT_W = 2**IN_W;
  localparam int SW   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0]   SETTLE_INIT = SW'(SETTLE_CYCLES - 1);
  localparam logic [IN_W-1:0] LAST_IDX    = IN_W'(TT_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [IN_W-1:0]   idx_q, idx_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [TT_W-1:0]   exp_q, exp_d;
  logic [TT_W-1:0]   tt_q, tt_d;
  logic [IN_W:0]     fail_cnt_q, fail_cnt_d;
  logic [IN_W-1:0]   fail_idx_q, fail_idx_d;
  logic              pass_q, pass_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_DRIVE;
      S_DRIVE:  if (settle_q == '0) state_d = S_SAMPLE;
      S_SAMPLE: state_d = (idx_q == LAST_IDX) ? S_DONE : S_DRIVE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    drv_in1 = (state_q == S_DRIVE || state_q == S_SAMPLE) ? idx_q : '0;
  end

  // datapath next-state; fail_cnt cannot exceed TT_W since each code is sampled once
  always_comb begin
    idx_d      = idx_q;
    settle_d   = settle_q;
    exp_d      = exp_q;
    tt_d       = tt_q;
    fail_cnt_d = fail_cnt_q;
    fail_idx_d = fail_idx_q;
    pass_d     = pass_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          exp_d      = expected_tt;
          tt_d       = '0;
          fail_cnt_d = '0;
          fail_idx_d = '0;
          pass_d     = 1'b0;
          idx_d      = '0;
          settle_d   = SETTLE_INIT;
        end
      end
      S_DRIVE: begin
        if (settle_q != '0) settle_d = settle_q - SW'(1);
      end
      S_SAMPLE: begin
        tt_d[idx_q] = dut_out1;
        if (dut_out1 != exp_q[idx_q]) begin
          fail_cnt_d = fail_cnt_q + (IN_W+1)'(1);
          if (fail_cnt_q == '0) fail_idx_d = idx_q;
        end
        if (idx_q != LAST_IDX) begin
          idx_d    = idx_q + IN_W'(1);
          settle_d = SETTLE_INIT;
        end
      end
      S_DONE: begin
        pass_d = (fail_cnt_q == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= '0;
      settle_q   <= '0;
      exp_q      <= '0;
      tt_q       <= '0;
      fail_cnt_q <= '0;
      fail_idx_q <= '0;
      pass_q     <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      settle_q   <= settle_d;
      exp_q      <= exp_d;
      tt_q       <= tt_d;
      fail_cnt_q <= fail_cnt_d;
      fail_idx_q <= fail_idx_d;
      pass_q     <= pass_d;
    end
  end

  assign tt       = tt_q;
  assign pass     = pass_q;
  assign fail_cnt = fail_cnt_q;
  assign fail_idx = fail_idx_q;

endmodule

// File: tb/tb_nibble_sweep_capture.sv
// Bench for nibble_sweep_capture: models the reduction block as a lookup table and checks
// captured tables, mismatch statistics, latency and start/reset handling.
module tb_nibble_sweep_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] expected_tt = '0;
  logic [3:0]  drv_in1;
  logic        dut_out1;
  logic        busy, done, pass;
  logic [15:0] tt;
  logic [4:0]  fail_cnt;
  logic [3:0]  fail_idx;

  logic [15:0] lut = '0;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;
  always_comb dut_out1 = lut[drv_in1];

  nibble_sweep_capture #(.IN_W(4), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .start(start), .expected_tt(expected_tt),
    .drv_in1(drv_in1), .dut_out1(dut_out1), .busy(busy), .done(done),
    .tt(tt), .pass(pass), .fail_cnt(fail_cnt), .fail_idx(fail_idx)
  );

  function automatic logic [15:0] and_or_lut();
    logic [15:0] r;
    for (int k = 0; k < 16; k++) r[k] = (k[3] & k[2]) | (k[1] & k[0]);
    return r;
  endfunction

  function automatic logic [15:0] xor_or_lut();
    logic [15:0] r;
    for (int k = 0; k < 16; k++) r[k] = (k[3] ^ k[2]) | (k[1] ^ k[0]);
    return r;
  endfunction

  function automatic int model_cnt(input logic [15:0] a, input logic [15:0] b);
    int c = 0;
    for (int k = 0; k < 16; k++) if (a[k] != b[k]) c++;
    return c;
  endfunction

  function automatic int model_idx(input logic [15:0] a, input logic [15:0] b);
    for (int k = 0; k < 16; k++) if (a[k] != b[k]) return k;
    return 0;
  endfunction

  // Accepts one sweep and observes it up to the first IDLE cycle after DONE (cycle T+34).
  task automatic do_sweep(input logic [15:0] exp_v, input logic [15:0] lut_v, input bit scramble,
                          output int done_cyc, output int n_done, output int drv_err);
    done_cyc = -1; n_done = 0; drv_err = 0;
    @(negedge clk);
    lut = lut_v; expected_tt = exp_v; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (scramble) expected_tt = 16'($urandom);
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      if (c <= 32 && (drv_in1 !== 4'((c - 1) / 2) || busy !== 1'b1)) drv_err++;
      if (c == 33 && (drv_in1 !== 4'd0 || busy !== 1'b1)) drv_err++;
      if (done === 1'b1) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; expected_tt = 16'hFFFF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_tests++;
      if ({drv_in1, busy, done, tt, pass, fail_cnt, fail_idx} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc%0d: got drv=%h busy=%b done=%b tt=%h pass=%b cnt=%0d idx=%0d, want all 0",
                 i, drv_in1, busy, done, tt, pass, fail_cnt, fail_idx);
      end
    end
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy_after_release: got %b want 0", busy);
    end
  endtask

  task automatic check_result(input string nm, input logic [15:0] e_tt, input int e_cnt,
                              input int e_idx, input logic e_pass, input int done_cyc,
                              input int n_done, input int drv_err);
    // expectations are computed by the caller; this only reports observed vs required
    n_tests++;
    if (done_cyc != 33 || n_done != 1) begin
      n_fail++; $display("FAIL %s latency: done at T+%0d (%0d pulses), want T+33 (1 pulse)", nm, done_cyc, n_done);
    end
    n_tests++;
    if (drv_err != 0) begin
      n_fail++; $display("FAIL %s drv_sequence: %0d bad cycles, want 0", nm, drv_err);
    end
    n_tests++;
    if (tt !== e_tt || fail_cnt !== 5'(e_cnt) || fail_idx !== 4'(e_idx) || pass !== e_pass || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s result: tt=%h cnt=%0d idx=%0d pass=%b busy=%b, want tt=%h cnt=%0d idx=%0d pass=%b busy=0",
               nm, tt, fail_cnt, fail_idx, pass, busy, e_tt, e_cnt, e_idx, e_pass);
    end
  endtask

  task automatic test_and_or_pass();
    int dc, nd, de;
    do_sweep(16'hF888, and_or_lut(), 1'b0, dc, nd, de);
    check_result("and_or_pass", 16'hF888, 0, 0, 1'b1, dc, nd, de);
  endtask

  task automatic test_one_mismatch();
    int dc, nd, de;
    do_sweep(16'hF880, and_or_lut(), 1'b0, dc, nd, de);
    check_result("one_mismatch", 16'hF888, 1, 3, 1'b0, dc, nd, de);
  endtask

  task automatic test_xor_many();
    int dc, nd, de;
    do_sweep(16'h0000, xor_or_lut(), 1'b0, dc, nd, de);
    check_result("xor_many", 16'h6FF6, 12, 1, 1'b0, dc, nd, de);
  endtask

  task automatic test_back_to_back();
    int dones[$];
    @(negedge clk);
    lut = and_or_lut(); expected_tt = 16'hF888; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      if (done === 1'b1) dones.push_back(c);
      if (c == 34) begin
        n_tests++;
        if (busy !== 1'b0) begin
          n_fail++; $display("FAIL b2b_idle_gap: busy=%b at T+34, want 0", busy);
        end
      end
      start = (c == 5 || c == 33 || c == 34);
    end
    start = 1'b0;
    n_tests++;
    if (dones.size() != 2 || dones[0] != 33 || dones[1] != 67) begin
      n_fail++;
      $display("FAIL b2b_done_cycles: got %0d pulses first=T+%0d, want 2 at T+33,T+67",
               dones.size(), (dones.size() > 0) ? dones[0] : -1);
    end
    n_tests++;
    if (tt !== 16'hF888 || pass !== 1'b1 || fail_cnt !== 5'd0) begin
      n_fail++; $display("FAIL b2b_result: tt=%h pass=%b cnt=%0d, want F888 1 0", tt, pass, fail_cnt);
    end
  endtask

  task automatic test_mid_reset();
    int nd = 0, bz = 0;
    int dc, ndn, de;
    @(negedge clk);
    lut = and_or_lut(); expected_tt = 16'h0000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 12; c++) @(negedge clk);
    n_tests++;
    if (drv_in1 !== 4'd5 || busy !== 1'b1) begin
      n_fail++; $display("FAIL midrst_sample5: drv=%0d busy=%b, want 5 1", drv_in1, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if ({drv_in1, busy, done, tt, pass, fail_cnt, fail_idx} !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs: drv=%h busy=%b done=%b tt=%h pass=%b cnt=%0d idx=%0d, want all 0",
               drv_in1, busy, done, tt, pass, fail_cnt, fail_idx);
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
      if (busy !== 1'b0) bz++;
    end
    n_tests++;
    if (nd != 0 || bz != 0) begin
      n_fail++; $display("FAIL midrst_no_done: %0d done, %0d busy cycles, want 0 0", nd, bz);
    end
    do_sweep(16'hF888, and_or_lut(), 1'b0, dc, ndn, de);
    check_result("midrst_restart", 16'hF888, 0, 0, 1'b1, dc, ndn, de);
  endtask

  task automatic test_random();
    logic [15:0] l, e;
    int dc, nd, de, m_cnt;
    for (int it = 0; it < 20; it++) begin
      l = 16'($urandom);
      case (it)
        0:       e = l;
        1:       e = ~l;
        default: e = (it % 3 == 0) ? (l ^ (16'h1 << $urandom_range(0, 15))) : 16'($urandom);
      endcase
      do_sweep(e, l, 1'b1, dc, nd, de);
      m_cnt = model_cnt(l, e);
      check_result($sformatf("random%0d", it), l, m_cnt, model_idx(l, e), m_cnt == 0, dc, nd, de);
    end
  endtask

  initial begin
    test_reset();
    test_and_or_pass();
    test_one_mismatch();
    test_xor_many();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
